// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
// Round-robin arbiter that shares one cache request port among NUM_REQ
// requesters. The winner's payload is latched, a request is held toward the
// cache until cache_ready, and the result is handed back with a one-cycle
// req_done pulse. A watchdog aborts transactions the cache never completes.
// All outputs come straight from flops; nothing combinational reaches a port.

module cache_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_rw,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      cache_req,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  output logic                      cache_rw,
  input  logic [DATA_W-1:0]         cache_rdata,
  input  logic                      cache_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Registered state.
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_gnt;
  logic [IDX_W-1:0]   cur;

  // Next-state values produced by the combinational process.
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [IDX_W-1:0]   last_gnt_next;
  logic [IDX_W-1:0]   cur_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic [NUM_REQ-1:0] req_done_next;
  logic               req_err_next;
  logic [DATA_W-1:0]  resp_rdata_next;
  logic               cache_req_next;
  logic [ADDR_W-1:0]  cache_addr_next;
  logic [DATA_W-1:0]  cache_wdata_next;
  logic               cache_rw_next;

  // Arbitration result.
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Per-requester views of the flat payload buses.
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Index reached by stepping 'off' places past 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int               off);
    int sum;
    sum = (int'(base) + off) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Round-robin pick: first requesting index after last_gnt. Scanning from the
  // farthest candidate back to the nearest lets the nearest one win without a
  // found-flag chain.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[rr_index(last_gnt, off)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(last_gnt, off);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY/RESP transaction FSM.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    last_gnt_next    = last_gnt;
    cur_next         = cur;
    gnt_next         = gnt;
    req_done_next    = '0;
    req_err_next     = 1'b0;
    resp_rdata_next  = '0;
    cache_req_next   = 1'b0;
    cache_addr_next  = cache_addr;
    cache_wdata_next = cache_wdata;
    cache_rw_next    = cache_rw;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          cur_next           = pick_idx;
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
          cache_addr_next    = addr_arr[pick_idx];
          cache_wdata_next   = wdata_arr[pick_idx];
          cache_rw_next      = req_rw[pick_idx];
          cnt_next           = '0;
          cache_req_next     = 1'b1;
          state_next         = BUSY;
        end else begin
          gnt_next = '0;
        end
      end

      BUSY: begin
        if (cache_ready) begin
          // A completion on the same cycle as the timeout still counts.
          resp_rdata_next = cache_rdata;
          req_err_next    = 1'b0;
          req_done_next   = gnt;
          state_next      = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          resp_rdata_next = '0;
          req_err_next    = 1'b1;
          req_done_next   = gnt;
          state_next      = RESP;
        end else begin
          cnt_next       = cnt + 1'b1;
          cache_req_next = 1'b1;
        end
      end

      RESP: begin
        last_gnt_next = cur;
        gnt_next      = '0;
        state_next    = IDLE;
      end

      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_gnt    <= IDX_W'(NUM_REQ - 1);
      cur         <= '0;
      gnt         <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
      resp_rdata  <= '0;
      cache_req   <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      cache_rw    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      last_gnt    <= last_gnt_next;
      cur         <= cur_next;
      gnt         <= gnt_next;
      req_done    <= req_done_next;
      req_err     <= req_err_next;
      resp_rdata  <= resp_rdata_next;
      cache_req   <= cache_req_next;
      cache_addr  <= cache_addr_next;
      cache_wdata <= cache_wdata_next;
      cache_rw    <= cache_rw_next;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter
// Directed bench for cache_port_arbiter: a small cache model answers after a
// programmable number of request cycles; every result is compared against
// values worked out by hand from the intended cycle behaviour.

module tb_cache_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_err;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      cache_req;
  logic [ADDR_W-1:0]         cache_addr;
  logic [DATA_W-1:0]         cache_wdata;
  logic                      cache_rw;
  logic [DATA_W-1:0]         cache_rdata;
  logic                      cache_ready;

  // Cache model controls.
  logic                      model_en;
  int                        cache_lat;
  logic [DATA_W-1:0]         rdata_xor;
  int                        wait_cnt;

  int checks;
  int errors;

  cache_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rw      (req_rw),
    .gnt         (gnt),
    .req_done    (req_done),
    .req_err     (req_err),
    .resp_rdata  (resp_rdata),
    .cache_req   (cache_req),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rw    (cache_rw),
    .cache_rdata (cache_rdata),
    .cache_ready (cache_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache model: counts cycles with cache_req high and pulses cache_ready
  // when the count reaches cache_lat. Read data is the address xor a key;
  // outside the ready cycle the data bus carries all ones.
  initial begin
    cache_ready = 1'b0;
    cache_rdata = '1;
    wait_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      cache_ready = 1'b0;
      cache_rdata = '1;
      if (!model_en || !cache_req) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == cache_lat) begin
          cache_ready = 1'b1;
          cache_rdata = cache_addr ^ rdata_xor;
        end
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Advance until req_done is seen or the budget runs out; reports cycles
  // taken and how many of them had cache_req high.
  task automatic wait_done(input int max_cycles, output int n, output int reqc);
    n    = 0;
    reqc = 0;
    do begin
      tick();
      n++;
      if (cache_req) reqc++;
    end while (req_done == '0 && n < max_cycles);
  endtask

  initial begin
    int n;
    int reqc;
    int done_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] exp_gnt;
    logic seen;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_rw    = '0;
    model_en  = 1'b0;
    cache_lat = 1;
    rdata_xor = '0;

    // Reset state.
    do_reset();
    check("rst_gnt",        64'(gnt),        64'(0));
    check("rst_done",       64'(req_done),   64'(0));
    check("rst_err",        64'(req_err),    64'(0));
    check("rst_cache_req",  64'(cache_req),  64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_cache_addr", 64'(cache_addr), 64'(0));
    check("rst_cache_rw",   64'(cache_rw),   64'(0));

    // Single read from requester 1, cache answers on its 3rd request cycle.
    model_en = 1'b1;
    cache_lat = 3;
    rdata_xor = '0;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_1044;
    req_rw[1] = 1'b0;
    req = 3'b010;
    tick();
    check("rd_cache_req",  64'(cache_req),  64'(1));
    check("rd_gnt",        64'(gnt),        64'(3'b010));
    check("rd_cache_addr", 64'(cache_addr), 64'(32'h0000_1044));
    check("rd_cache_rw",   64'(cache_rw),   64'(0));
    wait_done(19, n, reqc);
    n++;
    reqc++;
    check("rd_latency",    64'(n),          64'(4));
    check("rd_req_cycles", 64'(reqc),       64'(3));
    check("rd_done",       64'(req_done),   64'(3'b010));
    check("rd_rdata",      64'(resp_rdata), 64'(32'h0000_1044));
    check("rd_err",        64'(req_err),    64'(0));
    req = '0;
    tick();
    check("rd_done_pulse", 64'(req_done),   64'(0));
    check("rd_gnt_clear",  64'(gnt),        64'(0));

    // Round robin: all three request continuously, cache latency 1.
    do_reset();
    check("rr_rst_cache_addr", 64'(cache_addr), 64'(0));
    cache_lat = 1;
    rdata_xor = 32'h5A5A_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 32'h0000_0100 + 32'(4 * i);
      done_cnt[i] = 0;
    end
    req_rw = '0;
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_done(20, n, reqc);
      exp_gnt = 3'b001 << (t % 3);
      check("rr_done", 64'(req_done), 64'(exp_gnt));
      check("rr_rdata", 64'(resp_rdata),
            64'((32'h0000_0100 + 32'(4 * (t % 3))) ^ 32'h5A5A_0000));
      check("rr_spacing", 64'(n), (t == 0) ? 64'(2) : 64'(3));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_done[i]) done_cnt[i]++;
      end
    end
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      check("rr_count", 64'(done_cnt[i]), 64'(2));
    end
    tick();

    // Write from requester 2; payload and req change mid-transaction.
    cache_lat = 4;
    req_addr[2*ADDR_W +: ADDR_W]  = 32'h0000_2000;
    req_wdata[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    req_rw[2] = 1'b1;
    req = 3'b100;
    tick();
    check("wr_cache_wdata", 64'(cache_wdata), 64'(32'hDEAD_BEEF));
    check("wr_cache_rw",    64'(cache_rw),    64'(1));
    check("wr_cache_addr",  64'(cache_addr),  64'(32'h0000_2000));
    req_addr[2*ADDR_W +: ADDR_W]  = 32'h0000_2F00;
    req_wdata[2*DATA_W +: DATA_W] = 32'h1234_5678;
    req_rw[2] = 1'b0;
    req = '0;
    tick();
    tick();
    check("wr_hold_wdata",  64'(cache_wdata), 64'(32'hDEAD_BEEF));
    check("wr_hold_addr",   64'(cache_addr),  64'(32'h0000_2000));
    check("wr_hold_rw",     64'(cache_rw),    64'(1));
    check("wr_hold_req",    64'(cache_req),   64'(1));
    check("wr_hold_gnt",    64'(gnt),         64'(3'b100));
    wait_done(20, n, reqc);
    check("wr_latency",     64'(n),           64'(2));
    check("wr_done",        64'(req_done),    64'(3'b100));
    check("wr_err",         64'(req_err),     64'(0));
    tick();
    check("wr_done_pulse",  64'(req_done),    64'(0));

    // Timeout: cache never answers.
    model_en = 1'b0;
    req_addr[0*ADDR_W +: ADDR_W] = 32'h0000_3000;
    req_rw[0] = 1'b0;
    req = 3'b001;
    wait_done(TIMEOUT + 10, n, reqc);
    check("to_req_cycles", 64'(reqc),       64'(TIMEOUT));
    check("to_latency",    64'(n),          64'(TIMEOUT + 1));
    check("to_done",       64'(req_done),   64'(3'b001));
    check("to_err",        64'(req_err),    64'(1));
    check("to_rdata",      64'(resp_rdata), 64'(0));
    req = '0;
    model_en = 1'b1;
    cache_lat = 2;
    rdata_xor = 32'h0000_00A5;
    tick();
    req_addr[0*ADDR_W +: ADDR_W] = 32'h0000_3004;
    req = 3'b001;
    wait_done(20, n, reqc);
    check("to_next_latency", 64'(n),          64'(3));
    check("to_next_done",    64'(req_done),   64'(3'b001));
    check("to_next_err",     64'(req_err),    64'(0));
    check("to_next_rdata",   64'(resp_rdata), 64'(32'h0000_3004 ^ 32'h0000_00A5));
    req = '0;
    tick();

    // Ready on the same cycle the watchdog expires: ready wins.
    cache_lat = TIMEOUT;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_4000;
    req_rw[1] = 1'b0;
    req = 3'b010;
    wait_done(TIMEOUT + 10, n, reqc);
    check("co_latency", 64'(n),          64'(TIMEOUT + 1));
    check("co_done",    64'(req_done),   64'(3'b010));
    check("co_err",     64'(req_err),    64'(0));
    check("co_rdata",   64'(resp_rdata), 64'(32'h0000_4000 ^ 32'h0000_00A5));
    req = '0;
    tick();

    // Reset in the 5th BUSY cycle, then all three request: requester 0 first.
    model_en = 1'b0;
    req = 3'b100;
    tick();
    check("rb_busy", 64'(cache_req), 64'(1));
    repeat (4) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check("rb_cache_req", 64'(cache_req), 64'(0));
    check("rb_gnt",       64'(gnt),       64'(0));
    check("rb_done",      64'(req_done),  64'(0));
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (req_done != '0) seen = 1'b1;
    end
    check("rb_no_done", 64'(seen), 64'(0));
    model_en = 1'b1;
    cache_lat = 1;
    req = 3'b111;
    tick();
    check("rb_first_gnt", 64'(gnt), 64'(3'b001));
    wait_done(10, n, reqc);
    check("rb_first_done", 64'(req_done), 64'(3'b001));
    req = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one cache controller request port between NUM_REQ requesters (CPU fetch, CPU load/store, DMA) using round-robin arbitration.
- Latches the winner's address, write data and rw, then holds a request to the cache until `cache_ready` pulses, and returns the read data or write completion to the winner.
- Includes a watchdog that ends any transaction the cache has not completed within TIMEOUT cycles and flags it as an error.
- Sits between the requester buses and the cache controller.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles to wait for `cache_ready` before aborting (must be ≥ 2*MEM_DELAY+4; worst-case miss is 42).
- CNT_W, 7, width of the watchdog counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, held high until `req_done`.
- req_addr  in  NUM_REQ*ADDR_W  flat address bus; requester i owns slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flat write-data bus; same slicing.
- req_rw  in  NUM_REQ  0=read, 1=write.
- gnt  out  NUM_REQ  one-hot, marks the requester currently being served.
- req_done  out  NUM_REQ  one-cycle completion pulse to the served requester.
- req_err  out  1  valid together with `req_done`; 1 = watchdog timeout.
- resp_rdata  out  DATA_W  read data, valid together with `req_done`.
- cache_req  out  1  request to the cache, held until `cache_ready` or timeout.
- cache_addr  out  ADDR_W  latched address.
- cache_wdata  out  DATA_W  latched write data.
- cache_rw  out  1  latched rw.
- cache_rdata  in  DATA_W  cache read data, valid when `cache_ready`=1.
- cache_ready  in  1  one-cycle completion pulse from the cache.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State IDLE.
  - gnt, req_done, req_err, cache_req = 0; resp_rdata, cache_addr, cache_wdata, cache_rw = 0.
  - last_gnt = NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter = 0.
  - Reset mid-transaction abandons it silently: no `req_done` is issued and `cache_req` drops on the next cycle.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any `req` bit is set, pick the first set index searching upward from last_gnt+1 with modulo NUM_REQ wrap.
  - Latch that requester's addr, wdata and rw into the cache_* registers; set gnt one-hot; clear the counter; go to BUSY.
  - If no `req` bit is set, stay in IDLE with all outputs deasserted.
- BUSY:
  - `cache_req`=1; cache_* outputs and gnt remain stable.
  - On `cache_ready`=1: capture `cache_rdata` into resp_rdata (for a write the captured value is don't-care); req_err=0; go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: resp_rdata=0, req_err=1, go to RESP.
  - Otherwise increment the counter.
  - If `cache_ready` and the timeout coincide, `cache_ready` wins and req_err=0.
- RESP (exactly one cycle):
  - `cache_req`=0.
  - `req_done` = gnt, with req_err and resp_rdata valid.
  - last_gnt updated to the served index.
  - Next state IDLE; gnt clears on leaving RESP.
- Latency:
  - `req` sampled in IDLE at edge k gives `cache_req` high during cycle k+1.
  - `cache_ready` sampled at edge m gives `req_done` high during cycle m+1.
  - With no other requesters, a new request from the same requester is accepted 2 cycles after `req_done` at the earliest.
- Requester rule: deassert `req` (or change its payload) on the edge that samples `req_done`. The arbiter ignores `req` while in BUSY and RESP.
- A requester dropping `req` while in BUSY has no effect; the transaction completes.
- `cache_ready` while in IDLE or RESP is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,… with no starvation.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Single read: req[1]=1, addr=0x0000_1044, rw=0; cache model returns ready 3 cycles after `cache_req` with rdata=0x0000_1044 → cache_addr=0x0000_1044, cache_rw=0; req_done=3'b010 for one cycle with resp_rdata=0x0000_1044 and req_err=0.
- Round-robin: all three requesters assert together and re-request immediately after each done; cache ready latency is 1 → grant order 0,1,2,0,1,2; each requester gets exactly 2 done pulses in the first 6 transactions.
- Write pass-through: req[2]=1, rw=1, addr=0x0000_2000, wdata=0xDEAD_BEEF → cache_wdata=0xDEAD_BEEF and cache_rw=1 while `cache_req` is high; one req_done[2] pulse; payload stable throughout BUSY even when the requester changes req_wdata mid-transaction.
- Timeout: the cache never asserts ready → `cache_req` held exactly TIMEOUT cycles, then req_done pulses with req_err=1 and resp_rdata=0; the next request is served normally.
- Ready coincident with timeout: ready asserted on the cycle the counter equals TIMEOUT-1 → req_err=0 and resp_rdata equals cache_rdata.
- Reset mid-BUSY: rst=1 for 1 cycle at cycle 5 of BUSY → the next cycle shows cache_req=0, gnt=0, no req_done; a following req[0] is granted first.
